move_recorder: RTL and testbench
================================

Name: move_recorder

Overview:
- Input-side counterpart of the 7-segment move display: records player/operator button presses as a packed sequence of 2-bit direction codes.
- Produces the ord (packed moves) and cnt (move count) buses that the display/solver path consumes.
- Buttons are sampled on a slow tick, edge-detected with press/release flags, and recorded into a bounded move buffer that supports undo and clear.

Parameters:
- TICK_W, 10, width of the free-running sample-tick counter; tick every 2^TICK_W clocks.
- MAX_MOVES, 32, buffer capacity in moves; must be ≤ 32 so the buffer fits in ord[63:0].

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- btn  in  5  raw buttons: [4]=UP, [3]=DOWN, [2]=LEFT, [1]=RIGHT, [0]=UNDO
- clr  in  1  synchronous clear of the recorded sequence
- lock  in  1  when high, presses are tracked but not recorded (solver busy)
- ord  out  64  packed moves; move i at ord[2i+1:2i]
- cnt  out  64  number of recorded moves, 0..MAX_MOVES
- full  out  1  high when cnt == MAX_MOVES
- rec_pulse  out  1  one-clock strobe on each accepted move or undo
- ovf_pulse  out  1  one-clock strobe when a direction press is dropped because the buffer is full

Behaviour:
- Reset: reset rst_n, synchronous, active-low; clock clk. On reset: ord=0, cnt=0, full=0, rec_pulse=0, ovf_pulse=0, tick counter=0, press flags=0, synchronizer=0, state=EMPTY.
- Synchronizer: btn passes through 2 flops every clock; press logic uses only the synchronized value (btn_s).
- Tick: TICK_W-bit counter increments every clock, wraps; tick is asserted when counter==0.
- Press detect, evaluated on a tick only:
  - new[i] = btn_s[i] & ~flag[i].
  - flag[i] is set for every new[i].
  - flag[i] is cleared on a tick where btn_s[i]=0.
- Simultaneous new presses: only the highest-priority one acts (UP > DOWN > LEFT > RIGHT > UNDO). All their flags are still set, so the lower-priority ones never act later.
- Direction codes: UP=2'd0, DOWN=2'd1, LEFT=2'd2, RIGHT=2'd3.
- Record, when the action is a direction, lock=0 and cnt < MAX_MOVES:
  - ord[2*cnt +: 2] <= code, cnt <= cnt+1, rec_pulse=1.
- Full: the same press with cnt == MAX_MOVES leaves ord/cnt unchanged and sets ovf_pulse=1.
- Undo, when lock=0 and cnt > 0:
  - cnt <= cnt-1, ord[2*(cnt-1) +: 2] <= 0, rec_pulse=1.
  - Undo at cnt=0 is a no-op with no pulse.
- Lock: when lock=1, flags update normally but no record, undo or ovf occurs. A button held across the lock deassertion does not act.
- Clear: clr has priority over any tick action in the same cycle.
  - Sets ord=0, cnt=0, state=EMPTY.
  - Flags and tick counter are untouched, so a held button does not re-fire.
- Latency: ord/cnt/pulses change on the clock edge that ends the tick cycle. Worst case from btn change to ord update is 2 sync clocks + 2^TICK_W clocks + 1.
- Pulses are registered and high for exactly one clock.
- Bit hygiene: ord bits ≥ 2*MAX_MOVES are always 0; cnt[63:6] are always 0.
- State machine, with transitions taken only on accepted actions or clr:
  - EMPTY → REC on a record.
  - REC → FULL when a record makes cnt == MAX_MOVES.
  - REC → EMPTY when an undo makes cnt == 0.
  - FULL → REC on undo.
  - any state → EMPTY on clr.
  - full = (state == FULL).
- Reset mid-operation: all state is discarded in the same cycle; a held button after reset fires once on the first tick.

Decomposition:
- Shared package / def header: direction code constants UP/DOWN/LEFT/RIGHT (shared with the display and solver); button index constants BTN_UP=4, BTN_DOWN=3, BTN_LEFT=2, BTN_RIGHT=1, BTN_UNDO=0; state encoding EMPTY/REC/FULL.
- Sub-module btn_edge (parameter N=5): owns the synchronizer, tick counter and press flags; outputs the one-clock new[N-1:0] and tick. move_recorder holds the priority select, buffer, counter and FSM.

Test Plan:
- Reset, then hold UP, DOWN, LEFT, RIGHT one at a time across ticks (TICK_W=2) → cnt=4, ord[7:0]=8'b11_10_01_00, four rec_pulse strobes, each button recorded once despite being held 3 ticks.
- Press UP and RIGHT together on the same tick → only UP recorded (cnt=1, ord[1:0]=0); releasing UP while RIGHT stays held records nothing more.
- Record 32 moves of RIGHT → full=1, ord=64'hFFFF_FFFF_FFFF_FFFF; a 33rd press gives ovf_pulse=1, cnt stays 32. Then UNDO → cnt=31, ord[63:62]=0, full=0.
- UNDO at cnt=0 → no pulse, ord=0, cnt=0. Record LEFT then UNDO → cnt=0, ord=0, state EMPTY.
- lock=1 while pressing DOWN → nothing recorded. Deassert lock with DOWN still held → still nothing. Release and re-press → cnt=1, ord[1:0]=1.
- clr asserted in the same cycle as an accepted UP tick with cnt=5 → cnt=0, ord=0, no rec_pulse. Drop rst_n mid-hold of LEFT → all outputs 0; after release of reset, LEFT records once.

Source files
------------

// File: rtl/move_recorder_pkg.sv
// move_recorder_pkg: direction codes, button indices, recorder state encoding
// and the press priority selector shared by the move recorder.
`timescale 1ns/1ps
`default_nettype none

package move_recorder_pkg;

  // Direction codes shared with the display and solver path
  localparam logic [1:0] UP    = 2'd0;
  localparam logic [1:0] DOWN  = 2'd1;
  localparam logic [1:0] LEFT  = 2'd2;
  localparam logic [1:0] RIGHT = 2'd3;

  localparam int BTN_UP    = 4;
  localparam int BTN_DOWN  = 3;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_UNDO  = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    REC   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       undo;
    logic [1:0] code;
  } action_t;

  // Highest-priority new press wins: UP > DOWN > LEFT > RIGHT > UNDO
  function automatic action_t prio_select(input logic [4:0] presses);
    action_t a;
    a.valid = 1'b1;
    a.undo  = 1'b0;
    a.code  = UP;
    if (presses[BTN_UP]) begin
      a.code = UP;
    end else if (presses[BTN_DOWN]) begin
      a.code = DOWN;
    end else if (presses[BTN_LEFT]) begin
      a.code = LEFT;
    end else if (presses[BTN_RIGHT]) begin
      a.code = RIGHT;
    end else if (presses[BTN_UNDO]) begin
      a.undo = 1'b1;
    end else begin
      a.valid = 1'b0;
    end
    return a;
  endfunction

endpackage

`default_nettype wire

// File: rtl/move_recorder_btn_edge.sv
// btn_edge: two-flop button synchronizer, free-running sample tick and
// press flags; emits one-clock new-press strobes on tick cycles only.
`timescale 1ns/1ps
`default_nettype none

module btn_edge #(
  parameter int N      = 5,
  parameter int TICK_W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] btn,
  output logic [N-1:0] new_press,
  output logic         tick
);

  logic [N-1:0]      sync1;
  logic [N-1:0]      btn_s;
  logic [N-1:0]      flag;
  logic [TICK_W-1:0] tick_cnt;

  assign tick      = (tick_cnt == '0);
  assign new_press = tick ? (btn_s & ~flag) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= '0;
      btn_s    <= '0;
      flag     <= '0;
      tick_cnt <= '0;
    end else begin
      sync1    <= btn;
      btn_s    <= sync1;
      tick_cnt <= tick_cnt + 1'b1;
      // A flag latches on a new press and drops once the button reads released
      if (tick) begin
        flag <= (flag | new_press) & btn_s;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/move_recorder.sv
// move_recorder: records debounced button presses as packed 2-bit moves with
// undo, clear, lock and a bounded buffer; feeds ord/cnt to the display path.
`timescale 1ns/1ps
`default_nettype none

module move_recorder
  import move_recorder_pkg::*;
#(
  parameter int TICK_W    = 10,
  parameter int MAX_MOVES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  btn,
  input  logic        clr,
  input  logic        lock,
  output logic [63:0] ord,
  output logic [63:0] cnt,
  output logic        full,
  output logic        rec_pulse,
  output logic        ovf_pulse
);

  localparam logic [5:0] MAX_CNT = 6'(MAX_MOVES);

  logic [4:0]  new_press;
  logic        tick;
  action_t     act;
  logic [5:0]  count;
  logic [5:0]  count_m1;
  logic [63:0] ord_r;
  logic [5:0]  rec_idx;
  logic [5:0]  undo_idx;
  logic        is_dir;
  logic        do_rec;
  logic        do_ovf;
  logic        do_undo;
  state_t      state;
  state_t      next_state;

  btn_edge #(
    .N      (5),
    .TICK_W (TICK_W)
  ) u_btn_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .new_press (new_press),
    .tick      (tick)
  );

  assign act      = prio_select(new_press);
  assign count_m1 = count - 6'd1;
  // Record only happens below capacity and undo only above zero, so both
  // slot numbers stay within 0..31
  assign rec_idx  = {count[4:0], 1'b0};
  assign undo_idx = {count_m1[4:0], 1'b0};

  // Lock and clear both suppress every buffer action
  assign is_dir  = tick & act.valid & ~act.undo & ~lock & ~clr;
  assign do_rec  = is_dir & (count < MAX_CNT);
  assign do_ovf  = is_dir & (count == MAX_CNT);
  assign do_undo = tick & act.valid & act.undo & ~lock & ~clr & (count != 6'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ord_r     <= '0;
      count     <= '0;
      rec_pulse <= 1'b0;
      ovf_pulse <= 1'b0;
    end else begin
      rec_pulse <= do_rec | do_undo;
      ovf_pulse <= do_ovf;
      if (clr) begin
        ord_r <= '0;
        count <= '0;
      end else if (do_rec) begin
        ord_r[rec_idx +: 2] <= act.code;
        count               <= count + 6'd1;
      end else if (do_undo) begin
        ord_r[undo_idx +: 2] <= 2'd0;
        count                <= count_m1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (clr) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (do_rec) begin
            next_state = (count + 6'd1 == MAX_CNT) ? FULL : REC;
          end
        end
        REC: begin
          if (do_rec && (count + 6'd1 == MAX_CNT)) begin
            next_state = FULL;
          end else if (do_undo && (count_m1 == 6'd0)) begin
            next_state = EMPTY;
          end
        end
        FULL: begin
          if (do_undo) begin
            next_state = (count_m1 == 6'd0) ? EMPTY : REC;
          end
        end
        default: next_state = EMPTY;
      endcase
    end
  end

  always_comb begin
    full = (state == FULL);
  end

  assign ord = ord_r;
  assign cnt = {58'd0, count};

endmodule

`default_nettype wire

// File: tb/tb_move_recorder.sv
// tb_move_recorder: table-driven directed vectors plus hand sequences for
// the full buffer, tick-aligned clear and reset-during-hold cases.
`timescale 1ns/1ps
`default_nettype none

module tb_move_recorder;

  logic        clk;
  logic        rst_n;
  logic [4:0]  btn;
  logic        clr;
  logic        lock;
  logic [63:0] ord;
  logic [63:0] cnt;
  logic        full;
  logic        rec_pulse;
  logic        ovf_pulse;

  move_recorder #(
    .TICK_W    (2),
    .MAX_MOVES (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .clr       (clr),
    .lock      (lock),
    .ord       (ord),
    .cnt       (cnt),
    .full      (full),
    .rec_pulse (rec_pulse),
    .ovf_pulse (ovf_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side model of the sample-tick phase: tick cycles are ph == 0
  logic [1:0] ph;
  always @(posedge clk) begin
    if (!rst_n) ph <= 2'd0;
    else        ph <= ph + 2'd1;
  end

  localparam logic [4:0] B_NONE  = 5'b00000;
  localparam logic [4:0] B_UP    = 5'b10000;
  localparam logic [4:0] B_DOWN  = 5'b01000;
  localparam logic [4:0] B_LEFT  = 5'b00100;
  localparam logic [4:0] B_RIGHT = 5'b00010;
  localparam logic [4:0] B_UNDO  = 5'b00001;

  typedef struct {
    logic [4:0]  b;
    logic        l;
    int          cyc;
    logic [63:0] e_cnt;
    logic [63:0] e_ord;
    logic        e_full;
    int          e_rec;
    int          e_ovf;
  } vec_t;

  vec_t tbl[34];
  int   n_vec;
  int   n_bad;
  int   rec_seen;
  int   ovf_seen;
  int   rec_total;
  int   ovf_total;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge: drive inputs, then count pulses over n clocks
  task automatic run(input logic [4:0] b, input logic l, input int n);
    btn = b;
    lock = l;
    rec_seen = 0;
    ovf_seen = 0;
    repeat (n) begin
      @(negedge clk);
      rec_seen += int'(rec_pulse);
      ovf_seen += int'(ovf_pulse);
    end
  endtask

  task automatic check_state(input string nm, input logic [63:0] e_cnt,
                             input logic [63:0] e_ord, input logic e_full);
    check({nm, ".cnt"}, cnt, e_cnt);
    check({nm, ".ord"}, ord, e_ord);
    check({nm, ".full"}, {63'd0, full}, {63'd0, e_full});
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    btn   = B_NONE;
    clr   = 1'b0;
    lock  = 1'b0;
    rst_n = 1'b0;

    tbl[0]  = '{B_UP,           1'b0, 12, 64'd1, 64'h00, 1'b0, 1, 0};
    tbl[1]  = '{B_NONE,         1'b0,  8, 64'd1, 64'h00, 1'b0, 0, 0};
    tbl[2]  = '{B_DOWN,         1'b0, 12, 64'd2, 64'h04, 1'b0, 1, 0};
    tbl[3]  = '{B_NONE,         1'b0,  8, 64'd2, 64'h04, 1'b0, 0, 0};
    tbl[4]  = '{B_LEFT,         1'b0, 12, 64'd3, 64'h24, 1'b0, 1, 0};
    tbl[5]  = '{B_NONE,         1'b0,  8, 64'd3, 64'h24, 1'b0, 0, 0};
    tbl[6]  = '{B_RIGHT,        1'b0, 12, 64'd4, 64'hE4, 1'b0, 1, 0};
    tbl[7]  = '{B_NONE,         1'b0,  8, 64'd4, 64'hE4, 1'b0, 0, 0};
    tbl[8]  = '{B_UP | B_RIGHT, 1'b0, 12, 64'd5, 64'hE4, 1'b0, 1, 0};
    tbl[9]  = '{B_RIGHT,        1'b0, 12, 64'd5, 64'hE4, 1'b0, 0, 0};
    tbl[10] = '{B_NONE,         1'b0,  8, 64'd5, 64'hE4, 1'b0, 0, 0};
    tbl[11] = '{B_UNDO,         1'b0, 12, 64'd4, 64'hE4, 1'b0, 1, 0};
    tbl[12] = '{B_NONE,         1'b0,  8, 64'd4, 64'hE4, 1'b0, 0, 0};
    tbl[13] = '{B_UNDO,         1'b0, 12, 64'd3, 64'h24, 1'b0, 1, 0};
    tbl[14] = '{B_NONE,         1'b0,  8, 64'd3, 64'h24, 1'b0, 0, 0};
    tbl[15] = '{B_UNDO,         1'b0, 12, 64'd2, 64'h04, 1'b0, 1, 0};
    tbl[16] = '{B_NONE,         1'b0,  8, 64'd2, 64'h04, 1'b0, 0, 0};
    tbl[17] = '{B_UNDO,         1'b0, 12, 64'd1, 64'h00, 1'b0, 1, 0};
    tbl[18] = '{B_NONE,         1'b0,  8, 64'd1, 64'h00, 1'b0, 0, 0};
    tbl[19] = '{B_UNDO,         1'b0, 12, 64'd0, 64'h00, 1'b0, 1, 0};
    tbl[20] = '{B_NONE,         1'b0,  8, 64'd0, 64'h00, 1'b0, 0, 0};
    tbl[21] = '{B_UNDO,         1'b0, 12, 64'd0, 64'h00, 1'b0, 0, 0};
    tbl[22] = '{B_NONE,         1'b0,  8, 64'd0, 64'h00, 1'b0, 0, 0};
    tbl[23] = '{B_LEFT,         1'b0, 12, 64'd1, 64'h02, 1'b0, 1, 0};
    tbl[24] = '{B_NONE,         1'b0,  8, 64'd1, 64'h02, 1'b0, 0, 0};
    tbl[25] = '{B_UNDO,         1'b0, 12, 64'd0, 64'h00, 1'b0, 1, 0};
    tbl[26] = '{B_NONE,         1'b0,  8, 64'd0, 64'h00, 1'b0, 0, 0};
    tbl[27] = '{B_DOWN,         1'b1, 12, 64'd0, 64'h00, 1'b0, 0, 0};
    tbl[28] = '{B_DOWN,         1'b0, 12, 64'd0, 64'h00, 1'b0, 0, 0};
    tbl[29] = '{B_NONE,         1'b0,  8, 64'd0, 64'h00, 1'b0, 0, 0};
    tbl[30] = '{B_DOWN,         1'b0, 12, 64'd1, 64'h01, 1'b0, 1, 0};
    tbl[31] = '{B_NONE,         1'b0,  8, 64'd1, 64'h01, 1'b0, 0, 0};
    tbl[32] = '{B_UNDO,         1'b0, 12, 64'd0, 64'h00, 1'b0, 1, 0};
    tbl[33] = '{B_NONE,         1'b0,  8, 64'd0, 64'h00, 1'b0, 0, 0};

    // Reset state
    repeat (3) @(negedge clk);
    check_state("reset", 64'd0, 64'd0, 1'b0);
    check("reset.rec_pulse", {63'd0, rec_pulse}, 64'd0);
    check("reset.ovf_pulse", {63'd0, ovf_pulse}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 34; i++) begin
      run(tbl[i].b, tbl[i].l, tbl[i].cyc);
      check_state($sformatf("vec%0d", i), tbl[i].e_cnt, tbl[i].e_ord, tbl[i].e_full);
      check($sformatf("vec%0d.rec", i), 64'(rec_seen), 64'(tbl[i].e_rec));
      check($sformatf("vec%0d.ovf", i), 64'(ovf_seen), 64'(tbl[i].e_ovf));
    end

    // Fill the buffer with 32 RIGHT moves
    rec_total = 0;
    ovf_total = 0;
    for (int i = 0; i < 32; i++) begin
      run(B_RIGHT, 1'b0, 8);
      rec_total += rec_seen;
      ovf_total += ovf_seen;
      run(B_NONE, 1'b0, 8);
      rec_total += rec_seen;
      ovf_total += ovf_seen;
    end
    check_state("fill", 64'd32, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    check("fill.rec", 64'(rec_total), 64'd32);
    check("fill.ovf", 64'(ovf_total), 64'd0);

    // 33rd press overflows
    run(B_RIGHT, 1'b0, 8);
    check("ovf.ovf", 64'(ovf_seen), 64'd1);
    check("ovf.rec", 64'(rec_seen), 64'd0);
    check_state("ovf", 64'd32, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    run(B_NONE, 1'b0, 8);

    run(B_UNDO, 1'b0, 8);
    check_state("undo_full", 64'd31, 64'h3FFF_FFFF_FFFF_FFFF, 1'b0);
    check("undo_full.rec", 64'(rec_seen), 64'd1);
    run(B_NONE, 1'b0, 8);

    // Plain clear
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    check_state("clr", 64'd0, 64'd0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      run(B_UP, 1'b0, 8);
      run(B_NONE, 1'b0, 8);
    end
    check_state("five_up", 64'd5, 64'd0, 1'b0);

    // Clear coinciding with the tick that would accept a fresh UP press
    for (int i = 0; i < 8 && ph != 2'd1; i++) @(negedge clk);
    btn = B_UP;
    @(negedge clk);
    for (int i = 0; i < 8 && ph != 2'd0; i++) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    rec_seen = int'(rec_pulse);
    check("clr_tick.rec", 64'(rec_seen), 64'd0);
    check_state("clr_tick", 64'd0, 64'd0, 1'b0);
    run(B_UP, 1'b0, 12);
    check("clr_hold.rec", 64'(rec_seen), 64'd0);
    check_state("clr_hold", 64'd0, 64'd0, 1'b0);
    run(B_NONE, 1'b0, 8);

    // Reset in the middle of holding LEFT
    run(B_LEFT, 1'b0, 12);
    check_state("pre_rst", 64'd1, 64'd2, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_state("mid_rst", 64'd0, 64'd0, 1'b0);
    check("mid_rst.pulses", {62'd0, rec_pulse, ovf_pulse}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(B_LEFT, 1'b0, 16);
    check("post_rst.rec", 64'(rec_seen), 64'd1);
    check_state("post_rst", 64'd1, 64'd2, 1'b0);
    run(B_NONE, 1'b0, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
